// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter enabled with `define INSTRET_CNT_EN.
module multicycle_control #(
  parameter int ALUCTRL_W = 3,
  parameter int IMMSRC_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 adr_src,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 reg_we,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic [IMMSRC_W-1:0]  imm_src,
  output logic [1:0]           result_src,
  output logic                 illegal,
  output logic [31:0]          instret
);
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t      state_q, state_d;
  logic        illegal_q;
  logic [2:0]  alu_sel, imm_sel, alu_base;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        f3_ok, f7_ok;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  assign f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                 (funct3 == 3'b110) || (funct3 == 3'b111);
  assign f7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

  always_comb begin
    alu_base = 3'd0;
    case (funct3)
      3'b010:  alu_base = 3'd5;
      3'b100:  alu_base = 3'd4;
      3'b110:  alu_base = 3'd3;
      3'b111:  alu_base = 3'd2;
      default: alu_base = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_sel    = 3'd0;
    imm_sel    = 3'd0;
    result_src = 2'd0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target from oldPC + B-immediate
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_sel   = 3'd2;
        case (opcode)
          OP_R:         state_d = (f3_ok && f7_ok) ? S_EXEC_R : S_TRAP;
          OP_I:         state_d = f3_ok ? S_EXEC_I : S_TRAP;
          OP_LD, OP_ST: state_d = S_MEMADR;
          OP_BR:        state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'd2;
        alu_sel   = (funct3 == 3'b000 && funct7[5]) ? 3'd1 : alu_base;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_sel   = alu_base;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_sel   = opcode[5] ? 3'd1 : 3'd0;
        state_d   = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        result_src = 2'd1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'd2;
        alu_sel   = 3'd1;
        pc_we     = funct3[0] ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        imm_sel   = 3'd3;
        pc_we     = 1'b1;
        reg_we    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_RST;
    endcase
  end

  assign alu_ctrl = ALUCTRL_W'(alu_sel);
  assign imm_src  = IMMSRC_W'(imm_sel);
  assign illegal  = illegal_q;

`ifdef INSTRET_CNT_EN
  // Any entry into FETCH other than a fetch stall or reset exit completes an instruction
  logic        retire;
  logic [31:0] instret_q;
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_RST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end
  assign instret = instret_q;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction cycle sequences from the ISA rules,
// expected outputs queued by the driver and compared by a negedge monitor.
module tb_multicycle_control;
  logic        clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = '0, nxt_instr = '0;
  logic        mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_ctrl, imm_src;
  logic [31:0] instret;

  multicycle_control #(.ALUCTRL_W(3), .IMMSRC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_we(ir_we), .pc_we(pc_we),
    .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .imm_src(imm_src), .result_src(result_src), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

`ifdef INSTRET_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23,
                         OP_BR = 7'h63, OP_JAL = 7'h6F;

  typedef struct packed {
    logic        mem_req, mem_we, adr, ir_we, pc_we, reg_we;
    logic [1:0]  a, b;
    logic [2:0]  alu, imm;
    logic [1:0]  rs;
    logic        ill;
    logic [31:0] ir;
  } out_t;

  out_t        exp_q[$];
  string       tag_q[$];
  int          errors = 0, checks = 0;
  int unsigned cnt = 0;
  int          force_z = -1;
  out_t        mon_e, mon_a;
  string       mon_t;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, alu_src_a, alu_src_b,
               alu_ctrl, imm_src, result_src, illegal, instret};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s @%0t: got %h expected %h", mon_t, $time, mon_a, mon_e);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic out_t base();
    out_t o;
    o = '0;
    o.ir = CNT ? cnt : 32'd0;
    return o;
  endfunction

  function automatic bit alu_f3_ok(logic [2:0] f3);
    return f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7;
  endfunction

  function automatic logic [2:0] alu_ref(logic [2:0] f3, bit sub);
    case (f3)
      3'd0:    return sub ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit legal(logic [31:0] ins);
    case (ins[6:0])
      OP_R:                 return alu_f3_ok(ins[14:12]) && (ins[31:25] == 7'h00 || ins[31:25] == 7'h20);
      OP_I:                 return alu_f3_ok(ins[14:12]);
      OP_LD, OP_ST, OP_JAL: return 1'b1;
      OP_BR:                return ins[14:13] == 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  task automatic step(input logic rn, input logic rdy, input logic z, input out_t e, input string t);
    @(posedge clk); #1;
    rst_n = rn; instr = nxt_instr; mem_ready = rdy; zero = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic do_reset(input int n);
    cnt = 0;
    for (int i = 0; i < n; i++) step(1'b0, rb(), rb(), base(), "reset");
    step(1'b1, rb(), rb(), base(), "rst_state");
  endtask

  // abort >= 0: reset is asserted after that many memory wait cycles
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int abort);
    out_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic z;
    op = ins[6:0];
    f3 = ins[14:12];
    nxt_instr = ins;
    e = base(); e.mem_req = 1; e.b = 2'd2; e.rs = 2'd2;
    for (int i = 0; i < fw; i++) step(1'b1, 1'b0, rb(), e, "fetch_wait");
    e.ir_we = 1; e.pc_we = 1;
    step(1'b1, 1'b1, rb(), e, "fetch");
    e = base(); e.a = 2'd1; e.b = 2'd1; e.imm = 3'd2;
    step(1'b1, rb(), rb(), e, "decode");
    if (!legal(ins)) begin
      e = base(); e.ill = 1;
      for (int i = 0; i < 10; i++) step(1'b1, rb(), rb(), e, "trap");
      do_reset(2);
      return;
    end
    case (op)
      OP_R, OP_I: begin
        e = base(); e.a = 2'd2; e.b = (op == OP_I) ? 2'd1 : 2'd0;
        e.alu = alu_ref(f3, op == OP_R && ins[30]);
        step(1'b1, rb(), rb(), e, "exec");
        e = base(); e.reg_we = 1;
        step(1'b1, rb(), rb(), e, "alu_wb");
      end
      OP_LD, OP_ST: begin
        e = base(); e.a = 2'd2; e.b = 2'd1; e.imm = (op == OP_ST) ? 3'd1 : 3'd0;
        step(1'b1, rb(), rb(), e, "mem_adr");
        e = base(); e.mem_req = 1; e.adr = 1; e.mem_we = (op == OP_ST);
        for (int i = 0; i < mw; i++) begin
          if (i == abort) begin
            do_reset(2);
            return;
          end
          step(1'b1, 1'b0, rb(), e, "mem_wait");
        end
        step(1'b1, 1'b1, rb(), e, "mem_done");
        if (op == OP_LD) begin
          e = base(); e.reg_we = 1; e.rs = 2'd1;
          step(1'b1, rb(), rb(), e, "mem_wb");
        end
      end
      OP_BR: begin
        z = (force_z < 0) ? rb() : force_z[0];
        e = base(); e.a = 2'd2; e.alu = 3'd1; e.pc_we = (f3 == 3'd0) ? z : ~z;
        step(1'b1, rb(), z, e, "branch");
      end
      default: begin
        e = base(); e.a = 2'd1; e.b = 2'd2; e.imm = 3'd3; e.pc_we = 1; e.reg_we = 1;
        step(1'b1, rb(), rb(), e, "jal");
      end
    endcase
    cnt++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 9: begin
        r[6:0] = OP_R;
        if ($urandom_range(0, 7) != 0) r[31:25] = rb() ? 7'h20 : 7'h00;
      end
      2, 3: r[6:0] = OP_I;
      4:    r[6:0] = OP_LD;
      5:    r[6:0] = OP_ST;
      6: begin
        r[6:0] = OP_BR;
        if ($urandom_range(0, 3) != 0) r[14:13] = 2'b00;
      end
      7:    r[6:0] = OP_JAL;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    run_instr(32'h002081B3, 0, 0, -1);   // add
    run_instr(32'h402081B3, 1, 0, -1);   // sub
    run_instr(32'h0050E193, 0, 0, -1);   // ori
    run_instr(32'h0000A183, 0, 3, -1);   // lw, 3 wait cycles
    run_instr(32'h0020A023, 2, 1, -1);   // sw
    for (int i = 0; i < 4; i++) begin    // beq/bne with zero forced 1 then 0
      force_z = (i % 2 == 0) ? 1 : 0;
      run_instr((i < 2) ? 32'h00208063 : 32'h00209063, 0, 0, -1);
    end
    force_z = -1;
    run_instr(32'h000000EF, 0, 0, -1);   // jal
    run_instr(32'h0000007F, 0, 0, -1);   // illegal opcode, then reset
    run_instr(32'h002081B3, 0, 0, -1);
    run_instr(32'h0020A023, 0, 3, 2);    // sw aborted by reset mid-write
    for (int i = 0; i < 150; i++)
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), -1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
